// File: rtl/gray_sweep_ctrl_if.sv
// rtl/gray_sweep_ctrl_if.sv - valid/ready stream carrying captured (binary, Gray) pairs
interface gray_sweep_ctrl_if #(parameter int WIDTH = 4);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic [WIDTH-1:0] out_gray;

  modport master (output out_valid, output out_bin, output out_gray, input out_ready);
  modport slave  (input out_valid, input out_bin, input out_gray, output out_ready);
endinterface

// File: rtl/gray_sweep_ctrl.sv
// rtl/gray_sweep_ctrl.sv - sweeps a binary count through a Gray converter and streams checked pairs
module gray_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode,
  input  logic                    dir,
  output logic [WIDTH-1:0]        conv_in,
  input  logic [WIDTH-1:0]        conv_gray,
  gray_sweep_ctrl_if.master       stream,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0]    RELOAD = TW'(DIV - 1);
  localparam logic [WIDTH-1:0] ALL1   = '1;

  typedef enum logic [1:0] {IDLE, HOLD, PRESENT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [TW-1:0]    timer;
  logic             mode_r;
  logic             dir_r;
  logic             have_prev;
  logic [WIDTH-1:0] prev_gray;

  logic             hs;
  logic             terminal;
  logic [WIDTH-1:0] next_count;
  logic             adj_bad;

  function automatic int popcount(input logic [WIDTH-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < WIDTH; i++) n += int'(v[i]);
    return n;
  endfunction

  // The count register is the converter input; in IDLE it simply keeps its last value.
  assign conv_in    = count;
  assign hs         = stream.out_valid & stream.out_ready;
  assign terminal   = dir_r ? (count == '0) : (count == ALL1);
  // Modulo arithmetic makes the continuous-mode wrap the same as an ordinary step.
  assign next_count = dir_r ? (count - 1'b1) : (count + 1'b1);
  assign adj_bad    = (popcount(prev_gray ^ stream.out_gray) != 1);

  // Sweep sequencer: settle timer, capture, handshake, adjacency check and abort handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      timer           <= '0;
      mode_r          <= 1'b0;
      dir_r           <= 1'b0;
      have_prev       <= 1'b0;
      prev_gray       <= '0;
      stream.out_valid <= 1'b0;
      stream.out_bin  <= '0;
      stream.out_gray <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            count     <= dir ? ALL1 : '0;
            mode_r    <= mode;
            dir_r     <= dir;
            timer     <= RELOAD;
            err       <= 1'b0;
            have_prev <= 1'b0;
            busy      <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (stop) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (timer == '0) begin
            stream.out_bin   <= count;
            stream.out_gray  <= conv_gray;
            stream.out_valid <= 1'b1;
            state            <= PRESENT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        PRESENT: begin
          if (hs) begin
            if (have_prev && adj_bad) err <= 1'b1;
            have_prev        <= 1'b1;
            prev_gray        <= stream.out_gray;
            stream.out_valid <= 1'b0;
            if (stop) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (terminal && !mode_r) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              count <= next_count;
              timer <= RELOAD;
              state <= HOLD;
            end
          end else if (stop) begin
            stream.out_valid <= 1'b0;
            busy             <= 1'b0;
            state            <= IDLE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// tb/tb_gray_sweep_ctrl.sv - self-checking bench for gray_sweep_ctrl
module tb_gray_sweep_ctrl;
  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic         dir = 1'b0;
  logic [W-1:0] conv_in;
  logic [W-1:0] conv_gray;
  logic         busy;
  logic         done;
  logic         err;
  logic         faulty = 1'b0;

  gray_sweep_ctrl_if #(.WIDTH(W)) sif ();

  gray_sweep_ctrl #(.WIDTH(W), .DIV(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dir       (dir),
    .conv_in   (conv_in),
    .conv_gray (conv_gray),
    .stream    (sif),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // External converter: correct Gray, or a broken one passing binary through.
  assign conv_gray = faulty ? conv_in : (conv_in ^ (conv_in >> 1));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] seen_gray[$];
  int           beats = 0;
  int           done_cnt = 0;
  int           start_cyc = 0;
  int           first_rise = -1;
  int           last_rise = 0;
  logic         chk_spacing = 1'b0;
  logic         m_err = 1'b0;
  logic         m_have = 1'b0;
  logic [W-1:0] m_prev = '0;
  logic         prev_valid = 1'b0;
  logic         prev_done = 1'b0;
  int           ready_mode = 0;

  logic [W-1:0] up_tbl [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] g_of(input logic [W-1:0] b, input logic f);
    return f ? b : (b ^ (b >> 1));
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Toggling consumer: flips out_ready every 3 cycles when enabled.
  initial begin
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 2) begin
        n++;
        if (n == 3) begin
          n = 0;
          sif.out_ready = ~sif.out_ready;
        end
      end
    end
  end

  // Compare process: checks the stream and err against the beat model every cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("err", int'(err), int'(m_err));
      if (sif.out_valid) begin
        chk("busy_with_valid", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("valid_without_expected_beat", int'(sif.out_valid), 0);
        end else begin
          chk("out_bin", int'(sif.out_bin), int'(exp_q[0]));
          chk("out_gray", int'(sif.out_gray), int'(g_of(exp_q[0], faulty)));
        end
        if (!prev_valid) begin
          if (beats == 0) first_rise = cyc - start_cyc;
          else if (chk_spacing) chk("beat_spacing", cyc - last_rise, D + 1);
          last_rise = cyc;
        end
        if (sif.out_ready && exp_q.size() > 0) begin
          logic [W-1:0] g;
          g = g_of(exp_q[0], faulty);
          if (m_have && ($countones(m_prev ^ g) != 1)) m_err = 1'b1;
          m_have = 1'b1;
          m_prev = g;
          seen_gray.push_back(sif.out_gray);
          void'(exp_q.pop_front());
          beats++;
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_width", int'(prev_done), 0);
        chk("busy_at_done", int'(busy), 0);
      end
      if (stop && busy) exp_q.delete();
      if (start && !busy && !done) begin
        m_err = 1'b0;
        m_have = 1'b0;
        start_cyc = cyc;
        beats = 0;
      end
      prev_valid = sif.out_valid;
      prev_done = done;
    end else begin
      exp_q.delete();
      m_err = 1'b0;
      m_have = 1'b0;
      prev_valid = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_start(input logic m, input logic d, input logic f, input int nb);
    exp_q.delete();
    seen_gray.delete();
    for (int i = 0; i < nb; i++) exp_q.push_back(d ? W'(15 - (i % 16)) : W'(i % 16));
    done_cnt = 0;
    first_rise = -1;
    faulty = f;
    mode = m;
    dir = d;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k;
    k = 0;
    while (beats < n && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_beats", beats, n);
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_valid(input int budget);
    int k;
    k = 0;
    while (!sif.out_valid && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_valid", int'(sif.out_valid), 1);
  endtask

  initial begin
    sif.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) chk("model_gray", int'(g_of(W'(i), 1'b0)), int'(up_tbl[i]));

    // Reset state.
    tick(2);
    chk("rst_conv_in", int'(conv_in), 0);
    chk("rst_valid", int'(sif.out_valid), 0);
    chk("rst_bin", int'(sif.out_bin), 0);
    chk("rst_gray", int'(sif.out_gray), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    tick(2);

    // Single up sweep, ready always high.
    sif.out_ready = 1'b1;
    chk_spacing = 1'b1;
    do_start(1'b0, 1'b0, 1'b0, 16);
    chk("busy_after_start", int'(busy), 1);
    wait_idle(200);
    tick(2);
    chk_spacing = 1'b0;
    chk("up_beats", beats, 16);
    chk("up_done", done_cnt, 1);
    chk("up_first_valid", first_rise, 5);
    chk("up_err", int'(err), 0);
    for (int i = 0; i < 16; i++)
      if (i < seen_gray.size()) chk("up_gray_seq", int'(seen_gray[i]), int'(up_tbl[i]));

    // Single down sweep, consumer toggling.
    ready_mode = 2;
    do_start(1'b0, 1'b1, 1'b0, 16);
    wait_idle(400);
    ready_mode = 0;
    tick(2);
    chk("down_beats", beats, 16);
    chk("down_done", done_cnt, 1);
    chk("down_err", int'(err), 0);
    for (int i = 0; i < 16; i++)
      if (i < seen_gray.size()) chk("down_gray_seq", int'(seen_gray[i]), int'(up_tbl[15 - i]));

    // Continuous up sweep across the wrap, then stop.
    sif.out_ready = 1'b1;
    do_start(1'b1, 1'b0, 1'b0, 24);
    wait_beats(18, 200);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("cont_busy_after_stop", int'(busy), 0);
    tick(20);
    chk("cont_done", done_cnt, 0);
    chk("cont_err", int'(err), 0);
    if (seen_gray.size() > 16) begin
      chk("wrap_last_gray", int'(seen_gray[15]), 8);
      chk("wrap_first_gray", int'(seen_gray[16]), 0);
    end

    // Faulty converter: error after beat with bin 2, sticky.
    do_start(1'b0, 1'b0, 1'b1, 16);
    wait_beats(2, 100);
    chk("fault_err_before", int'(err), 0);
    wait_beats(3, 100);
    chk("fault_err_after", int'(err), 1);
    wait_idle(200);
    tick(1);
    chk("fault_err_sticky", int'(err), 1);

    // Stop in HOLD of beat 5; start also clears err.
    do_start(1'b0, 1'b0, 1'b0, 16);
    chk("start_clears_err", int'(err), 0);
    wait_beats(5, 100);
    tick(1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("hold_stop_busy", int'(busy), 0);
    tick(20);
    chk("hold_stop_beats", beats, 5);
    chk("hold_stop_done", done_cnt, 0);
    chk("hold_stop_valid", int'(sif.out_valid), 0);

    // Stop coincident with a handshake.
    do_start(1'b0, 1'b0, 1'b0, 16);
    wait_beats(1, 100);
    sif.out_ready = 1'b0;
    wait_valid(50);
    sif.out_ready = 1'b1;
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    sif.out_ready = 1'b0;
    chk("hs_stop_busy", int'(busy), 0);
    chk("hs_stop_valid", int'(sif.out_valid), 0);
    tick(10);
    chk("hs_stop_beats", beats, 2);
    chk("hs_stop_done", done_cnt, 0);

    // Asynchronous reset in PRESENT, then a fresh sweep.
    sif.out_ready = 1'b1;
    do_start(1'b0, 1'b0, 1'b1, 16);
    wait_beats(3, 100);
    sif.out_ready = 1'b0;
    wait_valid(50);
    chk("pre_reset_err", int'(err), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(sif.out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_err", int'(err), 0);
    chk("arst_conv_in", int'(conv_in), 0);
    chk("arst_bin", int'(sif.out_bin), 0);
    chk("arst_gray", int'(sif.out_gray), 0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    sif.out_ready = 1'b1;
    do_start(1'b0, 1'b0, 1'b0, 16);
    wait_idle(200);
    tick(2);
    chk("fresh_beats", beats, 16);
    chk("fresh_done", done_cnt, 1);
    chk("fresh_err", int'(err), 0);
    if (seen_gray.size() > 0) chk("fresh_first_gray", int'(seen_gray[0]), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
